hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard control for a short in-order pipeline: tracks the EX/MEM/WB
// destination records, produces forwarding selects and load-use / multiply
// stalls for the instruction sitting in decode.
module hazard_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int MUL_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 D_valid,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  input  logic                 D_use_ra,
  input  logic                 D_use_rb,
  input  logic [ADDR_SIZE-1:0] D_rd,
  input  logic                 D_we,
  input  logic                 D_ld,
  input  logic                 D_mul,
  input  logic                 EX_flush,
  output logic [1:0]           EX_D_bp,
  output logic [1:0]           MEM_D_bp,
  output logic [1:0]           WB_D_bp,
  output logic                 stall_F,
  output logic                 stall_D,
  output logic                 mul_busy
);

  typedef struct packed {
    logic                 valid;
    logic [ADDR_SIZE-1:0] rd;
    logic                 we;
    logic                 ld;
    logic                 mul;
  } slot_t;

  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_FLUSH,
    UPD_BUBBLE,
    UPD_ISSUE
  } upd_t;

  slot_t      ex_q, mem_q, wb_q;
  logic [3:0] mcnt;
  logic [1:0] ex_hit, mem_hit, wb_hit;
  logic       lduse;
  upd_t       upd;
  slot_t      dec;
  logic       unused_fields;

  // Only the write-back identity of older slots matters downstream.
  assign unused_fields = ^{mem_q.ld, mem_q.mul, wb_q.ld, wb_q.mul, ex_q.mul};

  function automatic logic hit(slot_t s, logic [ADDR_SIZE-1:0] r, logic rd_en);
    return s.valid & s.we & (s.rd == r) & (r != '0) & rd_en;
  endfunction

  // Source matches, forwarding priority, stall decisions and update selection.
  always_comb begin
    ex_hit   = {hit(ex_q,  D_ra, D_use_ra), hit(ex_q,  D_rb, D_use_rb)};
    mem_hit  = {hit(mem_q, D_ra, D_use_ra), hit(mem_q, D_rb, D_use_rb)};
    wb_hit   = {hit(wb_q,  D_ra, D_use_ra), hit(wb_q,  D_rb, D_use_rb)};
    lduse    = ex_q.ld & (|ex_hit);
    mul_busy = (mcnt != '0);
    // A raw EX match still masks older stages even when EX forwarding is
    // suppressed, so a stale MEM/WB value is never selected during a stall.
    EX_D_bp  = (lduse | mul_busy) ? 2'b00 : ex_hit;
    MEM_D_bp = mem_hit & ~ex_hit;
    WB_D_bp  = wb_hit & ~ex_hit & ~mem_hit;
    stall_D  = D_valid & (lduse | mul_busy) & ~EX_flush;
    stall_F  = stall_D;
    dec      = '{valid: D_valid, rd: D_rd, we: D_we, ld: D_ld, mul: D_mul};
    if (mul_busy)      upd = UPD_HOLD;
    else if (EX_flush) upd = UPD_FLUSH;
    else if (lduse)    upd = UPD_BUBBLE;
    else               upd = UPD_ISSUE;
  end

  // Slot pipeline and multiply occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      mcnt  <= '0;
    end else begin
      case (upd)
        UPD_HOLD: begin
          mcnt  <= mcnt - 4'd1;
          mem_q <= '0;
          wb_q  <= mem_q;
        end
        UPD_FLUSH, UPD_BUBBLE: begin
          ex_q  <= '0;
          mem_q <= ex_q;
          wb_q  <= mem_q;
        end
        default: begin
          ex_q  <= dec;
          mem_q <= ex_q;
          wb_q  <= mem_q;
          mcnt  <= (D_valid & D_mul) ? 4'(MUL_LAT - 1) : 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// decode traffic compared against a stage-list reference model.
module tb_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_valid = 1'b0, d_use_ra = 1'b0, d_use_rb = 1'b0;
  logic [AW-1:0] d_ra = '0, d_rb = '0, d_rd = '0;
  logic          d_we = 1'b0, d_ld = 1'b0, d_mul = 1'b0, d_flush = 1'b0;
  logic [1:0]    ex_bp, mem_bp, wb_bp;
  logic          stall_f, stall_d, busy;
  logic [8:0]    obs, exp_v;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  logic          mv[3], mwe[3], mld[3];
  logic [AW-1:0] mrd[3];
  int            mrem;
  logic          m_lu;

  always #5 clk = ~clk;

  assign obs = {ex_bp, mem_bp, wb_bp, stall_f, stall_d, busy};

  hazard_ctrl #(.ADDR_SIZE(AW), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .D_valid(d_valid), .D_ra(d_ra), .D_rb(d_rb),
    .D_use_ra(d_use_ra), .D_use_rb(d_use_rb), .D_rd(d_rd), .D_we(d_we),
    .D_ld(d_ld), .D_mul(d_mul), .EX_flush(d_flush), .EX_D_bp(ex_bp),
    .MEM_D_bp(mem_bp), .WB_D_bp(wb_bp), .stall_F(stall_f), .stall_D(stall_d),
    .mul_busy(busy)
  );

  task automatic drive(input logic v, input int ra, input int rb, input logic ua,
                       input logic ub, input int rd, input logic we,
                       input logic ld, input logic mul, input logic fl);
    d_valid = v; d_ra = AW'(ra); d_rb = AW'(rb); d_use_ra = ua; d_use_rb = ub;
    d_rd = AW'(rd); d_we = we; d_ld = ld; d_mul = mul; d_flush = fl;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; mwe[k] = 0; mld[k] = 0; mrd[k] = '0;
    end
    mrem = 0;
    m_lu = 0;
  endtask

  // Find the youngest producer for each source and derive the outputs.
  task automatic model_eval(output logic [8:0] e);
    int            p[2];
    logic [AW-1:0] src[2];
    logic          en[2];
    logic [1:0]    exb, memb, wbb;
    logic          bz, st;
    src[0] = d_ra; src[1] = d_rb; en[0] = d_use_ra; en[1] = d_use_rb;
    for (int i = 0; i < 2; i++) begin
      p[i] = -1;
      for (int k = 2; k >= 0; k--)
        if (mv[k] && mwe[k] && mrd[k] == src[i] && src[i] != 0 && en[i]) p[i] = k;
    end
    m_lu = mld[0] && (p[0] == 0 || p[1] == 0);
    bz = (mrem > 0);
    for (int i = 0; i < 2; i++) begin
      exb[1-i]  = (p[i] == 0) && !m_lu && !bz;
      memb[1-i] = (p[i] == 1);
      wbb[1-i]  = (p[i] == 2);
    end
    st = d_valid && (m_lu || bz) && !d_flush;
    e = {exb, memb, wbb, st, st, bz};
  endtask

  task automatic model_step();
    if (mrem > 0) begin
      mrem = mrem - 1;
      mv[2] = mv[1]; mwe[2] = mwe[1]; mld[2] = mld[1]; mrd[2] = mrd[1];
      mv[1] = 0; mwe[1] = 0; mld[1] = 0; mrd[1] = '0;
    end else begin
      for (int k = 2; k > 0; k--) begin
        mv[k] = mv[k-1]; mwe[k] = mwe[k-1]; mld[k] = mld[k-1]; mrd[k] = mrd[k-1];
      end
      if (d_flush || m_lu) begin
        mv[0] = 0; mwe[0] = 0; mld[0] = 0; mrd[0] = '0;
      end else begin
        mv[0] = d_valid; mwe[0] = d_we; mld[0] = d_ld; mrd[0] = d_rd;
        mrem = (d_valid && d_mul) ? LAT - 1 : 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 0;
    drive(1, 3, 3, 1, 1, 3, 1, 1, 0, 0);
    #2;
    vectors++;
    if (obs !== 9'b0) begin
      miscompares++; $display("FAIL reset_hold got %b exp %b", obs, 9'b0);
    end
    @(negedge clk); rst_n = 1;
    #1;
    vectors++;
    if (obs !== 9'b0) begin
      miscompares++; $display("FAIL reset_release got %b exp %b", obs, 9'b0);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_fwd_alu();
    do_reset();
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
    @(negedge clk); vectors++;
    if (obs !== 9'b100000000) begin
      miscompares++; $display("FAIL fwd_ex got %b exp %b", obs, 9'b100000000);
    end
    @(posedge clk); #1;
    drive(1, 3, 4, 1, 1, 9, 1, 0, 0, 0);
    @(negedge clk); vectors++;
    if (obs !== 9'b011000000) begin
      miscompares++; $display("FAIL fwd_ex_mem got %b exp %b", obs, 9'b011000000);
    end
    @(posedge clk); #1;
    drive(1, 4, 3, 1, 1, 10, 1, 0, 0, 0);
    @(negedge clk); vectors++;
    if (obs !== 9'b001001000) begin
      miscompares++; $display("FAIL fwd_mem_wb got %b exp %b", obs, 9'b001001000);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    @(negedge clk); vectors++;
    if (obs !== 9'b000000110) begin
      miscompares++; $display("FAIL lduse_stall got %b exp %b", obs, 9'b000000110);
    end
    @(posedge clk); #1;
    @(negedge clk); vectors++;
    if (obs !== 9'b001100000) begin
      miscompares++; $display("FAIL lduse_mem got %b exp %b", obs, 9'b001100000);
    end
  endtask

  task automatic test_mul();
    do_reset();
    drive(1, 1, 2, 1, 1, 7, 1, 0, 1, 0);
    @(posedge clk); #1;
    drive(1, 7, 0, 1, 1, 8, 1, 0, 0, 0);
    for (int c = 0; c < LAT - 1; c++) begin
      @(negedge clk); vectors++;
      if (obs !== 9'b000000111) begin
        miscompares++; $display("FAIL mul_stall%0d got %b exp %b", c, obs, 9'b000000111);
      end
      @(posedge clk); #1;
    end
    @(negedge clk); vectors++;
    if (obs !== 9'b100000000) begin
      miscompares++; $display("FAIL mul_fwd got %b exp %b", obs, 9'b100000000);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    @(negedge clk); vectors++;
    if (obs !== 9'b0) begin
      miscompares++; $display("FAIL x0_ld got %b exp %b", obs, 9'b0);
    end
    @(posedge clk); #1;
    @(negedge clk); vectors++;
    if (obs !== 9'b0) begin
      miscompares++; $display("FAIL x0_alu got %b exp %b", obs, 9'b0);
    end
  endtask

  task automatic test_flush_lduse();
    do_reset();
    drive(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
    @(negedge clk); vectors++;
    if (obs !== 9'b0) begin
      miscompares++; $display("FAIL flush_nostall got %b exp %b", obs, 9'b0);
    end
    @(posedge clk); #1;
    drive(1, 6, 5, 1, 1, 11, 1, 0, 0, 0);
    @(negedge clk); vectors++;
    if (obs !== 9'b000100000) begin
      miscompares++; $display("FAIL flush_after got %b exp %b", obs, 9'b000100000);
    end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    drive(1, 1, 2, 1, 1, 7, 1, 0, 1, 0);
    @(posedge clk); #1;
    drive(1, 7, 0, 1, 1, 8, 1, 0, 0, 0);
    @(negedge clk); vectors++;
    if (obs !== 9'b000000111) begin
      miscompares++; $display("FAIL rmul_busy got %b exp %b", obs, 9'b000000111);
    end
    #1 rst_n = 0;
    #1; vectors++;
    if (obs !== 9'b0) begin
      miscompares++; $display("FAIL rmul_async got %b exp %b", obs, 9'b0);
    end
    #1 rst_n = 1;
    @(posedge clk); #1; vectors++;
    if (obs !== 9'b0) begin
      miscompares++; $display("FAIL rmul_noreplay got %b exp %b", obs, 9'b0);
    end
  endtask

  task automatic test_random();
    logic ld, mul;
    do_reset();
    @(posedge clk); #1;
    model_step();
    for (int n = 0; n < 400; n++) begin
      ld  = ($urandom_range(0, 3) == 0);
      mul = !ld && ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 4) != 0, ld, mul, $urandom_range(0, 7) == 0);
      @(negedge clk);
      model_eval(exp_v);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL random%0d got %b exp %b", n, obs, exp_v);
      end
      @(posedge clk); #1;
      model_step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_mul();
    test_x0();
    test_flush_lduse();
    test_reset_mid_mul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
